// File: rtl/cpu_clk_ctrl.sv
// Execution controller for the MIPS core: produces a one-cycle CPU enable for
// halt / run / divided run / N-step burst modes, with a PC breakpoint.
module cpu_clk_ctrl #(
    parameter int PC_W       = 12,
    parameter int DIV_W      = 24,
    parameter int STEP_W     = 16,
    parameter int CNT_W      = 32,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_mode,
    input  logic              i_step,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [STEP_W-1:0] i_nstep,
    input  logic              i_bp_en,
    input  logic [PC_W-1:0]   i_bp_pc,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_cpu_en,
    output logic              o_bp_hit,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_instr_cnt
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, BURST, BP} state_t;

    state_t             state_q, state_d;
    logic               step_s1_q, step_s1_d;
    logic               step_s2_q, step_s2_d;
    logic               deb_lvl_q, deb_lvl_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               step_req_q, step_req_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               skip_q, skip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               raw_en;
    logic               bp_match;
    logic               cpu_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            deb_lvl_q  <= 1'b0;
            deb_cnt_q  <= '0;
            step_req_q <= 1'b0;
            rem_q      <= '0;
            div_q      <= '0;
            skip_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_s1_q  <= step_s1_d;
            step_s2_q  <= step_s2_d;
            deb_lvl_q  <= deb_lvl_d;
            deb_cnt_q  <= deb_cnt_d;
            step_req_q <= step_req_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            skip_q     <= skip_d;
            cnt_q      <= cnt_d;
        end
    end

    // Accepted level flips only after DEB_CYCLES consecutive differing samples;
    // step_req is registered on the flip to 1.
    always_comb begin
        step_s1_d  = i_step;
        step_s2_d  = step_s1_q;
        deb_lvl_d  = deb_lvl_q;
        deb_cnt_d  = '0;
        step_req_d = 1'b0;
        if (step_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_lvl_d  = step_s2_q;
                step_req_d = step_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        skip_d   = skip_q;
        raw_en   = 1'b0;
        bp_match = i_bp_en & (i_pc == i_bp_pc) & ~skip_q;

        case (state_q)
            IDLE: begin
                div_d = '0;
                case (i_mode)
                    2'b01, 2'b10: state_d = RUN;
                    2'b11: if (step_req_q) begin
                        state_d = BURST;
                        rem_d   = (i_nstep == '0) ? STEP_W'(1) : i_nstep;
                    end
                    default: ;
                endcase
            end
            RUN: begin
                case (i_mode)
                    2'b01: begin
                        raw_en = 1'b1;
                        div_d  = '0;
                    end
                    2'b10: begin
                        if (div_q == i_div) begin
                            raw_en = 1'b1;
                            div_d  = '0;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
                if (raw_en && bp_match) state_d = BP;
            end
            BURST: begin
                if (i_mode == 2'b00) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    raw_en = 1'b1;
                    // Breakpoint wins over the last enable of the burst.
                    if (bp_match) begin
                        state_d = BP;
                        rem_d   = '0;
                    end else if (rem_q == STEP_W'(1)) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - STEP_W'(1);
                    end
                end
            end
            BP: begin
                if (i_mode == 2'b00) begin
                    state_d = IDLE;
                end else if (step_req_q) begin
                    state_d = BURST;
                    rem_d   = STEP_W'(1);
                    skip_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_en = raw_en & ~bp_match;
        if (cpu_en) skip_d = 1'b0;
        cnt_d = cnt_q + CNT_W'(cpu_en);
    end

    assign o_cpu_en    = cpu_en;
    assign o_bp_hit    = (state_q == BP);
    assign o_busy      = (state_q == BURST);
    assign o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: run, divided run, step bursts, breakpoint, reset.
module tb_cpu_clk_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_mode;
    logic        i_step;
    logic [23:0] i_div;
    logic [15:0] i_nstep;
    logic        i_bp_en;
    logic [11:0] i_bp_pc;
    logic [11:0] i_pc;
    logic        o_cpu_en;
    logic        o_bp_hit;
    logic        o_busy;
    logic [31:0] o_instr_cnt;

    logic [11:0] pc_model;
    logic        pc_clr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Core model: PC advances on every enabled edge.
    always @(posedge clk) begin
        if (pc_clr) pc_model <= '0;
        else if (o_cpu_en) pc_model <= pc_model + 12'd1;
    end
    assign i_pc = pc_model;

    cpu_clk_ctrl dut (
        .clk(clk), .reset(reset), .i_mode(i_mode), .i_step(i_step),
        .i_div(i_div), .i_nstep(i_nstep), .i_bp_en(i_bp_en), .i_bp_pc(i_bp_pc),
        .i_pc(i_pc), .o_cpu_en(o_cpu_en), .o_bp_hit(o_bp_hit), .o_busy(o_busy),
        .o_instr_cnt(o_instr_cnt)
    );

    task automatic clear_pc();
        @(negedge clk); pc_clr = 1'b1;
        @(negedge clk); pc_clr = 1'b0;
    endtask

    // Press at a negedge; sample k is the negedge after posedge k.
    task automatic press_count(input int hold, input int window, output int n_en,
                               output int first_k, output int last_k, output int n_busy);
        n_en = 0; first_k = -1; last_k = -1; n_busy = 0;
        @(negedge clk); i_step = 1'b1;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (o_cpu_en) begin
                n_en++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (o_busy) n_busy++;
            if (k == hold) i_step = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_mode = 2'b00; i_step = 1'b0; i_div = '0; i_nstep = '0;
        i_bp_en = 1'b0; i_bp_pc = '0; pc_clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_cpu_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_cpu_en); end
        checks++; if (o_busy !== 1'b0 || o_bp_hit !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b bp=%b want 0 0", o_busy, o_bp_hit); end
        checks++; if (o_instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_instr_cnt); end
        reset = 1'b1; pc_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run();
        int bad = 0;
        i_mode = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_cpu_en !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL run_en got %0d idle cycles want 0", bad); end
        @(negedge clk);
        checks++; if (o_instr_cnt !== 32'd20) begin errors++; $display("FAIL run_cnt got %0d want 20", o_instr_cnt); end
        i_mode = 2'b00;
        @(negedge clk);
        checks++; if (o_cpu_en !== 1'b0) begin errors++; $display("FAIL run_halt_en got %b want 0", o_cpu_en); end
        checks++; if (o_instr_cnt !== 32'd20) begin errors++; $display("FAIL run_halt_cnt got %0d want 20", o_instr_cnt); end
    endtask

    task automatic test_div();
        int n = 0, last = -1, badgap = 0;
        logic [31:0] c0;
        i_div = 24'd3; i_mode = 2'b10;
        @(negedge clk);
        c0 = o_instr_cnt;
        for (int k = 1; k <= 40; k++) begin
            if (o_cpu_en) begin
                if (last >= 0 && k - last != 4) badgap++;
                last = k; n++;
            end
            if (k < 40) @(negedge clk);
        end
        @(negedge clk);
        checks++; if (n != 10) begin errors++; $display("FAIL div_enables got %0d want 10", n); end
        checks++; if (badgap != 0) begin errors++; $display("FAIL div_spacing got %0d bad gaps want 0", badgap); end
        checks++; if (o_instr_cnt !== c0 + 32'd10) begin errors++; $display("FAIL div_cnt got %0d want %0d", o_instr_cnt, c0 + 32'd10); end
        i_mode = 2'b00; repeat (2) @(negedge clk);
        i_div = '0; i_mode = 2'b10;
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_cpu_en) n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL div0_enables got %0d want 8", n); end
        i_mode = 2'b00; repeat (2) @(negedge clk);
    endtask

    task automatic test_step();
        int n, f, l, b, gl = 0;
        i_mode = 2'b11; i_nstep = 16'd5;
        repeat (2) @(negedge clk);
        press_count(8, 20, n, f, l, b);
        checks++; if (n != 5) begin errors++; $display("FAIL step_count got %0d want 5", n); end
        checks++; if (f != 7 || l != 11) begin errors++; $display("FAIL step_timing got first %0d last %0d want 7 11", f, l); end
        checks++; if (b != 5) begin errors++; $display("FAIL step_busy got %0d want 5", b); end
        for (int g = 0; g < 3; g++) begin
            @(negedge clk); i_step = 1'b1; if (o_cpu_en) gl++;
            @(negedge clk); i_step = 1'b0; if (o_cpu_en) gl++;
            @(negedge clk); if (o_cpu_en) gl++;
        end
        press_count(8, 20, n, f, l, b);
        checks++; if (gl != 0 || n != 5 || f != 7) begin errors++; $display("FAIL step_bounce got glitch_en %0d n %0d first %0d want 0 5 7", gl, n, f); end
        i_nstep = 16'd0;
        press_count(8, 20, n, f, l, b);
        checks++; if (n != 1 || f != 7) begin errors++; $display("FAIL step_nstep0 got n %0d first %0d want 1 7", n, f); end
    endtask

    task automatic test_breakpoint();
        int n = 0, en_at_bp = 0, f, l, b;
        logic [31:0] c0;
        i_mode = 2'b00;
        clear_pc();
        i_bp_en = 1'b1; i_bp_pc = 12'h010;
        c0 = o_instr_cnt;
        i_mode = 2'b01;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_bp_hit) break;
            if (pc_model == 12'h010 && o_cpu_en) en_at_bp++;
            if (o_cpu_en) n++;
        end
        checks++; if (n != 16 || pc_model !== 12'h010) begin errors++; $display("FAIL bp_stop got n %0d pc %h want 16 010", n, pc_model); end
        checks++; if (o_bp_hit !== 1'b1 || en_at_bp != 0) begin errors++; $display("FAIL bp_hit got hit %b en_at_bp %0d want 1 0", o_bp_hit, en_at_bp); end
        checks++; if (o_instr_cnt !== c0 + 32'd16) begin errors++; $display("FAIL bp_cnt got %0d want %0d", o_instr_cnt, c0 + 32'd16); end
        i_mode = 2'b10;
        repeat (4) @(negedge clk);
        checks++; if (o_bp_hit !== 1'b1 || o_cpu_en !== 1'b0) begin errors++; $display("FAIL bp_hold got hit %b en %b want 1 0", o_bp_hit, o_cpu_en); end
        i_mode = 2'b11;
        press_count(8, 20, n, f, l, b);
        checks++; if (n != 1 || pc_model !== 12'h011) begin errors++; $display("FAIL bp_step got n %0d pc %h want 1 011", n, pc_model); end
        checks++; if (o_bp_hit !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL bp_step_idle got hit %b busy %b want 0 0", o_bp_hit, o_busy); end
    endtask

    task automatic test_burst_bp();
        int n, f, l, b;
        clear_pc();
        i_bp_pc = 12'h007; i_nstep = 16'd100;
        press_count(8, 40, n, f, l, b);
        checks++; if (n != 7 || pc_model !== 12'h007) begin errors++; $display("FAIL burst_bp got n %0d pc %h want 7 007", n, pc_model); end
        checks++; if (o_bp_hit !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL burst_bp_flags got hit %b busy %b want 1 0", o_bp_hit, o_busy); end
        i_mode = 2'b00;
        @(negedge clk);
        checks++; if (o_bp_hit !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", o_bp_hit); end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, after = 0;
        i_bp_en = 1'b0; i_nstep = 16'd10; i_mode = 2'b11;
        repeat (2) @(negedge clk);
        @(negedge clk); i_step = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8) i_step = 1'b0;
            if (o_cpu_en) n++;
            if (n == 8) break;
        end
        checks++; if (n != 8 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_burst got n %0d busy %b want 8 1", n, o_busy); end
        reset = 1'b0;
        #1;
        checks++; if (o_cpu_en !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL mid_reset got en %b busy %b want 0 0", o_cpu_en, o_busy); end
        checks++; if (o_instr_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d want 0", o_instr_cnt); end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_cpu_en) after++;
        end
        checks++; if (after != 0 || o_instr_cnt !== 32'd0) begin errors++; $display("FAIL post_reset got en %0d cnt %0d want 0 0", after, o_instr_cnt); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_div();
        test_step();
        test_breakpoint();
        test_burst_bp();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Parametrised execution controller for the MIPS core. It generates a single-cycle CPU enable (`o_cpu_en`) and does not gate any clock. It supports halt, full-speed run, divided-rate run, N-instruction burst on a debounced step button, and a PC breakpoint. It sits between the board buttons/switches and the core's enable input, and generalises the existing two-bit clock-control / manual-clock scheme.

Parameters:
PC_W, 12, width of PC compared for breakpoint
DIV_W, 24, width of run-rate divider
STEP_W, 16, width of burst length
CNT_W, 32, width of executed-instruction counter
DEB_CYCLES, 4, stable cycles required to accept a step-button level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_mode  in  2  00 halt, 01 run full speed, 10 run divided, 11 step
i_step  in  1  raw step button, asynchronous, active-high
i_div  in  DIV_W  divided mode: one enable every i_div+1 cycles
i_nstep  in  STEP_W  instructions per step press; 0 treated as 1
i_bp_en  in  1  breakpoint enable
i_bp_pc  in  PC_W  breakpoint address
i_pc  in  PC_W  current core PC (instruction about to execute)
o_cpu_en  out  1  core advances one instruction on clk edge when 1
o_bp_hit  out  1  stopped at breakpoint
o_busy  out  1  burst in progress
o_instr_cnt  out  CNT_W  count of enable cycles issued, wraps

Behaviour:
- Reset: clk is the only clock; reset is asynchronous, active-low. On reset low, all state and outputs clear immediately: state IDLE, `o_cpu_en`=0, `o_bp_hit`=0, `o_busy`=0, `o_instr_cnt`=0, divider=0, sync/debounce=0. Reset mid-burst aborts the burst with no further enables.
- Step input path: 2-flop synchroniser, then debounce. The accepted level changes only after DEB_CYCLES consecutive equal samples. A rising edge of the accepted level gives a one-cycle `step_req`.
  - Latency from `i_step` rising to `step_req` is 2+DEB_CYCLES cycles.
- States:
  - IDLE: enable 0. Mode 01 -> RUN. Mode 10 -> RUN, divider cleared. Mode 11 with `step_req` -> BURST, remaining counter loaded with max(`i_nstep`,1).
  - RUN, mode 01: raw enable is 1 every cycle.
  - RUN, mode 10: the divider counts 0..`i_div`. Raw enable is 1 when divider==`i_div`, then the divider clears. `i_div`=0 equals full speed.
  - RUN exits: mode 00 or 11 -> IDLE next cycle.
  - BURST: raw enable 1 each cycle and remaining decrements. After the enable with remaining==1 -> IDLE. `o_busy`=1 throughout. Mode 00 -> IDLE (abort). Other mode changes are ignored until done. `step_req` during BURST is dropped.
  - BP: enable 0, `o_bp_hit`=1.
    - `step_req` (any mode except 00) -> BURST with remaining=1 and skip flag set.
    - Mode 00 -> IDLE, `o_bp_hit` cleared.
    - Mode 01/10 alone does not leave BP.
- Breakpoint: match = `i_bp_en` & (`i_pc`==`i_bp_pc`) & ~skip. `o_cpu_en` = raw_enable & ~match. This path is combinational from `i_pc`, zero latency.
  - If raw_enable & match in RUN or BURST -> next state BP, burst aborted.
  - skip clears on the first enable actually issued after it is set. This guarantees the breakpointed instruction executes once when stepped.
  - `i_bp_en`=0 never stops execution.
- Counter: `o_instr_cnt` increments on every cycle with `o_cpu_en`=1 and wraps from 2^CNT_W-1 to 0. It is not cleared on mode change.
- Simultaneous events: mode 00 has priority over `step_req` and breakpoint; breakpoint has priority over burst completion.

Test Plan:
1. Mode 01, `i_bp_en`=0, 20 cycles -> `o_cpu_en`=1 every cycle, `o_instr_cnt`=20. Mode 00 -> `o_cpu_en`=0 from next cycle.
2. Mode 10, `i_div`=3 -> `o_cpu_en` high 1 of every 4 cycles; 40 cycles -> `o_instr_cnt`=10.
3. Mode 11, `i_nstep`=5, clean step press -> exactly 5 consecutive enables starting 2+DEB_CYCLES+1 cycles after the press, `o_busy` high for those 5 cycles.
   - Button bouncing 1-cycle glitches before the press -> still exactly one burst.
   - `i_nstep`=0 -> exactly 1 enable.
4. Mode 01, `i_bp_en`=1, `i_bp_pc`=12'h010, bench PC model increments on enable from 0 -> 16 enables, `o_cpu_en`=0 while PC=0x010, `o_bp_hit`=1.
   - Step press -> one enable, PC=0x011, back in IDLE.
5. Mode 11 burst of 100 with breakpoint at PC 7 -> stops after 7 enables in BP, `o_busy`=0.
6. Assert reset low mid-burst (remaining 3) -> `o_cpu_en`, `o_busy`, `o_instr_cnt` = 0 immediately. After release, no enable until a new step press.
